// File: rtl/inst_queue.sv
// Show-ahead instruction FIFO between fetcher and issuer. Each entry holds
// an instruction and its PC. Provides early-full back-pressure, a single-cycle
// flush and a sticky overflow flag.
module inst_queue #(
  parameter int DEPTH      = 16,
  parameter int FULL_SLACK = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        valid_from_inst_fetcher,
  input  logic [31:0] inst_from_inst_fetcher,
  input  logic [31:0] pc_from_inst_fetcher,
  output logic        full_to_inst_fetcher,
  output logic        valid_to_issuer,
  output logic [31:0] inst_to_issuer,
  output logic [31:0] pc_to_issuer,
  input  logic        ready_from_issuer,
  input  logic        flush,
  output logic        overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_MARK = CW'(DEPTH - FULL_SLACK);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic has_space_s;
  logic push_s;
  logic pop_s;
  logic wr_en_s;

  // Handshake decode and next-state computation; capacity uses pre-cycle count.
  always_comb begin
    has_space_s = (count_q < DEPTH_C);
    push_s      = valid_from_inst_fetcher && has_space_s;
    pop_s       = (count_q != {CW{1'b0}}) && ready_from_issuer;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    err_d       = err_q;
    wr_en_s     = 1'b0;
    if (rdy) begin
      if (valid_from_inst_fetcher && !has_space_s) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
      if (flush) begin
        head_d  = {AW{1'b0}};
        tail_d  = {AW{1'b0}};
        count_d = {CW{1'b0}};
      end else begin
        wr_en_s = push_s;
        head_d  = head_q + AW'(pop_s);
        tail_d  = tail_q + AW'(push_s);
        count_d = count_q + CW'(push_s) - CW'(pop_s);
      end
    end else begin
      err_d = err_q;
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= {AW{1'b0}};
      tail_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (rst && wr_en_s) begin
      inst_mem_q[tail_q] <= inst_from_inst_fetcher;
      pc_mem_q[tail_q]   <= pc_from_inst_fetcher;
    end else begin
      inst_mem_q[tail_q] <= inst_mem_q[tail_q];
      pc_mem_q[tail_q]   <= pc_mem_q[tail_q];
    end
  end

  assign valid_to_issuer      = (count_q != {CW{1'b0}});
  assign inst_to_issuer       = inst_mem_q[head_q];
  assign pc_to_issuer         = pc_mem_q[head_q];
  assign full_to_inst_fetcher = (count_q >= FULL_MARK);
  assign overflow_err         = err_q;

endmodule

// File: tb/tb_inst_queue.sv
// Randomized and directed bench for inst_queue, checked against a
// queue-based reference model of the FIFO rules.
module tb_inst_queue;

  localparam int DEPTH      = 16;
  localparam int FULL_SLACK = 2;

  logic        clk = 1'b0;
  logic        rst, rdy, vld, rd, fl;
  logic [31:0] inst_i, pc_i;
  logic        full_o, valid_o, err_o;
  logic [31:0] inst_o, pc_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] model_q [$];
  logic        model_err = 1'b0;

  inst_queue #(.DEPTH(DEPTH), .FULL_SLACK(FULL_SLACK)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .rdy                     (rdy),
    .valid_from_inst_fetcher (vld),
    .inst_from_inst_fetcher  (inst_i),
    .pc_from_inst_fetcher    (pc_i),
    .full_to_inst_fetcher    (full_o),
    .valid_to_issuer         (valid_o),
    .inst_to_issuer          (inst_o),
    .pc_to_issuer            (pc_o),
    .ready_from_issuer       (rd),
    .flush                   (fl),
    .overflow_err            (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic check_state(input string ctx);
    logic [63:0] head;
    check({ctx, ".valid"}, 32'(valid_o), 32'(model_q.size() != 0));
    check({ctx, ".full"},  32'(full_o),  32'((DEPTH - model_q.size()) <= FULL_SLACK));
    check({ctx, ".err"},   32'(err_o),   32'(model_err));
    if (model_q.size() != 0) begin
      head = model_q[0];
      check({ctx, ".inst"}, inst_o, head[63:32]);
      check({ctx, ".pc"},   pc_o,   head[31:0]);
    end
  endtask

  // One clock: drive inputs, advance the model by the FIFO rules, then compare.
  task automatic cyc(input string ctx, input logic r, input logic e, input logic v,
                     input logic [31:0] ins, input logic [31:0] pc,
                     input logic rdi, input logic f);
    int  n;
    bit  do_push, do_pop;
    rst = r; rdy = e; vld = v; inst_i = ins; pc_i = pc; rd = rdi; fl = f;
    n = model_q.size();
    if (!r) begin
      model_q.delete();
      model_err = 1'b0;
    end else if (e) begin
      if (v && n == DEPTH) model_err = 1'b1;
      if (f) begin
        model_q.delete();
      end else begin
        do_push = v && (n < DEPTH);
        do_pop  = rdi && (n != 0);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back({ins, pc});
      end
    end
    @(posedge clk);
    #1;
    check_state(ctx);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; vld = 1'b0; rd = 1'b0; fl = 1'b0;
    inst_i = 32'h0; pc_i = 32'h0;
    #2;

    // Reset with push requested
    cyc("rst", 1'b0, 1'b1, 1'b1, 32'hdead_beef, 32'h0, 1'b0, 1'b0);
    cyc("rst", 1'b0, 1'b1, 1'b1, 32'hdead_beef, 32'h0, 1'b0, 1'b0);
    cyc("basic", 1'b1, 1'b1, 1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b0);
    check("basic.inst_lit", inst_o, 32'h0000_0013);
    cyc("basic_pop", 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill to full with no issuer
    for (int i = 0; i < DEPTH; i++) begin
      cyc("fill", 1'b1, 1'b1, 1'b1, $urandom, 32'(i * 4), 1'b0, 1'b0);
      if (i == 12) check("fill.full13", 32'(full_o), 32'h0);
      if (i == 13) check("fill.full14", 32'(full_o), 32'h1);
    end
    cyc("ovf", 1'b1, 1'b1, 1'b1, $urandom, 32'h44, 1'b0, 1'b0);
    check("ovf.err_lit", 32'(err_o), 32'h1);
    // Push 0x100 while popping at full: push dropped
    cyc("fullpp", 1'b1, 1'b1, 1'b1, $urandom, 32'h100, 1'b1, 1'b0);
    check("fullpp.pc_lit", pc_o, 32'h4);
    while (model_q.size() != 0)
      cyc("drain", 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Continuous push+pop wrap-around
    cyc("rst2", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++)
      cyc("wrap", 1'b1, 1'b1, 1'b1, $urandom, 32'(i * 4), 1'b1, 1'b0);

    // Flush alongside push
    while (model_q.size() != 0)
      cyc("drain2", 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      cyc("pre_fl", 1'b1, 1'b1, 1'b1, $urandom, 32'(i * 4), 1'b0, 1'b0);
    cyc("flush", 1'b1, 1'b1, 1'b1, $urandom, 32'h200, 1'b0, 1'b1);
    check("flush.valid_lit", 32'(valid_o), 32'h0);
    cyc("post_fl", 1'b1, 1'b1, 1'b1, $urandom, 32'h300, 1'b0, 1'b0);
    check("post_fl.pc_lit", pc_o, 32'h300);

    // rdy freeze with everything asserted
    cyc("pre_frz", 1'b1, 1'b1, 1'b1, $urandom, 32'h304, 1'b0, 1'b0);
    cyc("pre_frz", 1'b1, 1'b1, 1'b1, $urandom, 32'h308, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc("freeze", 1'b1, 1'b0, 1'b1, $urandom, 32'h400, 1'b1, 1'b1);
    check("freeze.pc_lit", pc_o, 32'h300);
    for (int i = 0; i < 4; i++)
      cyc("resume", 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc("rand",
          ($urandom_range(0, 199) != 0),
          ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 99) < 60),
          $urandom, $urandom,
          ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 30 : 70)),
          ($urandom_range(0, 49) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
